// File: rtl/draw_sprite_anim_if.sv
// Video timing/colour bus between display pipeline stages.
`timescale 1ns/1ps
interface draw_sprite_anim_if;
    logic [10:0] hcount;
    logic [10:0] vcount;
    logic        hsync;
    logic        vsync;
    logic        hblnk;
    logic        vblnk;
    logic [11:0] rgb;

    modport master (output hcount, vcount, hsync, vsync, hblnk, vblnk, rgb);
    modport slave  (input  hcount, vcount, hsync, vsync, hblnk, vblnk, rgb);
endinterface

// File: rtl/draw_sprite_anim.sv
// Animated sprite overlay: ship sprite with explosion frames, 2-cycle video pipeline.
// Optional macro DRAW_SPRITE_BLINK_EN: post-respawn blink with hit immunity.
`timescale 1ns/1ps
module draw_sprite_anim #(
    parameter int unsigned SPRITE_W          = 84,
    parameter int unsigned SPRITE_H          = 70,
    parameter int unsigned YPOS              = 680,
    parameter int unsigned X_W               = 7,
    parameter int unsigned Y_W               = 7,
    parameter int unsigned N_FRAMES          = 4,
    parameter int unsigned FRAME_TICKS       = 8,
    parameter logic [11:0] TRANSPARENT_COLOR = 12'hFFF
) (
    input  logic                                  pclk,
    input  logic                                  rst_n,
    draw_sprite_anim_if.slave                     vid_in,
    draw_sprite_anim_if.master                    vid_out,
    input  logic [11:0]                           rgb_pixel,
    input  logic [10:0]                           xpos,
    input  logic                                  hit,
    input  logic                                  respawn,
    output logic [$clog2(N_FRAMES)+Y_W+X_W-1:0]   pixel_addr,
    output logic [$clog2(N_FRAMES)-1:0]           frame_idx,
    output logic                                  anim_done
);

    localparam int unsigned FRAME_W = $clog2(N_FRAMES);
    localparam int unsigned TICK_W  = (FRAME_TICKS > 1) ? $clog2(FRAME_TICKS) : 1;

    typedef enum logic [1:0] {ALIVE, EXPLODE, DEAD} state_t;

    state_t              state, state_n;
    logic [FRAME_W-1:0]  frame_n;
    logic [TICK_W-1:0]   tick_cnt, tick_n;
    logic                hit_pend, hit_pend_n;
    logic                resp_pend, resp_pend_n;
    logic                done_n;
    logic                vblnk_prev;
    logic                frame_tick;
    logic                hit_take, resp_take;
    logic                hit_ok;
    logic                sprite_vis;

`ifdef DRAW_SPRITE_BLINK_EN
    logic                blink_on, blink_on_n;
    logic [5:0]          blink_cnt, blink_cnt_n;
    assign hit_ok     = ~blink_on;
    assign sprite_vis = (state != DEAD) && !(blink_on && blink_cnt[2]);
`else
    assign hit_ok     = 1'b1;
    assign sprite_vis = (state != DEAD);
`endif

    assign frame_tick = vid_in.vblnk & ~vblnk_prev;
    assign hit_take   = hit_pend  | (hit & hit_ok);
    assign resp_take  = resp_pend | respawn;

    // Animation state register; also tracks vblnk for rising-edge detection.
    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ALIVE;
            frame_idx  <= '0;
            tick_cnt   <= '0;
            hit_pend   <= 1'b0;
            resp_pend  <= 1'b0;
            anim_done  <= 1'b0;
            vblnk_prev <= 1'b0;
`ifdef DRAW_SPRITE_BLINK_EN
            blink_on   <= 1'b0;
            blink_cnt  <= '0;
`endif
        end else begin
            state      <= state_n;
            frame_idx  <= frame_n;
            tick_cnt   <= tick_n;
            hit_pend   <= hit_pend_n;
            resp_pend  <= resp_pend_n;
            anim_done  <= done_n;
            vblnk_prev <= vid_in.vblnk;
`ifdef DRAW_SPRITE_BLINK_EN
            blink_on   <= blink_on_n;
            blink_cnt  <= blink_cnt_n;
`endif
        end
    end

    // Next-state logic: requests latch as pending, state moves only on frame ticks.
    always_comb begin
        state_n     = state;
        frame_n     = frame_idx;
        tick_n      = tick_cnt;
        hit_pend_n  = hit_pend;
        resp_pend_n = resp_pend;
        done_n      = 1'b0;
`ifdef DRAW_SPRITE_BLINK_EN
        blink_on_n  = blink_on;
        blink_cnt_n = blink_cnt;
`endif
        case (state)
            ALIVE: begin
                if (frame_tick && hit_take) begin
                    state_n    = EXPLODE;
                    frame_n    = FRAME_W'(1);
                    tick_n     = '0;
                    hit_pend_n = 1'b0;
                end else begin
                    hit_pend_n = hit_take;
                end
`ifdef DRAW_SPRITE_BLINK_EN
                if (frame_tick && blink_on) begin
                    if (blink_cnt == 6'd63) begin
                        blink_on_n = 1'b0;
                    end else begin
                        blink_cnt_n = blink_cnt + 6'd1;
                    end
                end
`endif
            end
            EXPLODE: begin
                if (frame_tick) begin
                    if (tick_cnt == TICK_W'(FRAME_TICKS - 1)) begin
                        tick_n = '0;
                        if (frame_idx == FRAME_W'(N_FRAMES - 1)) begin
                            state_n = DEAD;
                            frame_n = '0;
                            done_n  = 1'b1;
                        end else begin
                            frame_n = frame_idx + FRAME_W'(1);
                        end
                    end else begin
                        tick_n = tick_cnt + TICK_W'(1);
                    end
                end
            end
            DEAD: begin
                if (frame_tick && resp_take) begin
                    state_n     = ALIVE;
                    frame_n     = '0;
                    resp_pend_n = 1'b0;
`ifdef DRAW_SPRITE_BLINK_EN
                    blink_on_n  = 1'b1;
                    blink_cnt_n = '0;
`endif
                end else begin
                    resp_pend_n = resp_take;
                end
            end
            default: state_n = ALIVE;
        endcase
    end

    // Window test and ROM offsets in 12 bits so a right-edge overflow clips.
    logic [11:0]    hc12, vc12, xs12, xe12, ys12, ye12;
    logic           in_win;
    logic [X_W-1:0] x_off;
    logic [Y_W-1:0] y_off;

    assign hc12   = {1'b0, vid_in.hcount};
    assign vc12   = {1'b0, vid_in.vcount};
    assign xs12   = {1'b0, xpos};
    assign xe12   = xs12 + 12'(SPRITE_W);
    assign ys12   = 12'(YPOS);
    assign ye12   = 12'(YPOS + SPRITE_H);
    assign in_win = (hc12 >= xs12) && (hc12 < xe12) && (vc12 >= ys12) && (vc12 < ye12);
    assign x_off  = X_W'(hc12 - xs12);
    assign y_off  = Y_W'(vc12 - ys12);

    logic [10:0] hc_d1, vc_d1;
    logic        hs_d1, vs_d1, hb_d1, vb_d1;
    logic [11:0] rgb_d1;
    logic        in_win_d1, vis_d1;

    // Stage 1: delay timing, issue ROM address, register window/visibility.
    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            hc_d1      <= '0;
            vc_d1      <= '0;
            hs_d1      <= 1'b0;
            vs_d1      <= 1'b0;
            hb_d1      <= 1'b0;
            vb_d1      <= 1'b0;
            rgb_d1     <= '0;
            in_win_d1  <= 1'b0;
            vis_d1     <= 1'b0;
            pixel_addr <= '0;
        end else begin
            hc_d1      <= vid_in.hcount;
            vc_d1      <= vid_in.vcount;
            hs_d1      <= vid_in.hsync;
            vs_d1      <= vid_in.vsync;
            hb_d1      <= vid_in.hblnk;
            vb_d1      <= vid_in.vblnk;
            rgb_d1     <= vid_in.rgb;
            in_win_d1  <= in_win;
            vis_d1     <= sprite_vis;
            pixel_addr <= {frame_idx, y_off, x_off};
        end
    end

    // Stage 2: blanking, then opaque sprite pixel over background.
    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            vid_out.hcount <= '0;
            vid_out.vcount <= '0;
            vid_out.hsync  <= 1'b0;
            vid_out.vsync  <= 1'b0;
            vid_out.hblnk  <= 1'b0;
            vid_out.vblnk  <= 1'b0;
            vid_out.rgb    <= '0;
        end else begin
            vid_out.hcount <= hc_d1;
            vid_out.vcount <= vc_d1;
            vid_out.hsync  <= hs_d1;
            vid_out.vsync  <= vs_d1;
            vid_out.hblnk  <= hb_d1;
            vid_out.vblnk  <= vb_d1;
            if (hb_d1 || vb_d1) begin
                vid_out.rgb <= '0;
            end else if (in_win_d1 && vis_d1 && (rgb_pixel != TRANSPARENT_COLOR)) begin
                vid_out.rgb <= rgb_pixel;
            end else begin
                vid_out.rgb <= rgb_d1;
            end
        end
    end

endmodule

// File: tb/tb_draw_sprite_anim.sv
// Directed bench for draw_sprite_anim (default build, blink disabled).
`timescale 1ns/1ps
module tb_draw_sprite_anim;

    logic        pclk = 1'b0;
    logic        rst_n;
    logic [11:0] rgb_pixel;
    logic [10:0] xpos;
    logic        hit, respawn;
    logic [15:0] pixel_addr;
    logic [1:0]  frame_idx;
    logic        anim_done;

    int checks   = 0;
    int failures = 0;
    int done_cnt = 0;
    logic last_done;

    draw_sprite_anim_if vid_in ();
    draw_sprite_anim_if vid_out ();

    draw_sprite_anim dut (
        .pclk       (pclk),
        .rst_n      (rst_n),
        .vid_in     (vid_in),
        .vid_out    (vid_out),
        .rgb_pixel  (rgb_pixel),
        .xpos       (xpos),
        .hit        (hit),
        .respawn    (respawn),
        .pixel_addr (pixel_addr),
        .frame_idx  (frame_idx),
        .anim_done  (anim_done)
    );

    always #5 pclk = ~pclk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge pclk);
        #1;
    endtask

    // Present a pixel and wait out the two-cycle pipeline.
    task automatic pix(input logic [10:0] h, input logic [10:0] v);
        vid_in.hcount = h;
        vid_in.vcount = v;
        step();
        step();
    endtask

    // One vblnk rising edge followed by a quiet cycle; tallies anim_done pulses.
    task automatic tick();
        vid_in.vblnk = 1'b1;
        step();
        last_done = anim_done;
        done_cnt += int'(anim_done);
        vid_in.vblnk = 1'b0;
        step();
        done_cnt += int'(anim_done);
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        rst_n = 1'b0;
        vid_in.hcount = 11'd100;
        vid_in.vcount = 11'd680;
        vid_in.hsync  = 1'b0;
        vid_in.vsync  = 1'b0;
        vid_in.hblnk  = 1'b0;
        vid_in.vblnk  = 1'b0;
        vid_in.rgb    = 12'h123;
        rgb_pixel = 12'h0F0;
        xpos      = 11'd100;
        hit       = 1'b0;
        respawn   = 1'b0;
        last_done = 1'b0;
        step();
        step();
        check("rst_rgb", 32'(vid_out.rgb), 32'h0);
        check("rst_hcount", 32'(vid_out.hcount), 32'h0);
        check("rst_frame", 32'(frame_idx), 32'h0);
        check("rst_addr", 32'(pixel_addr), 32'h0);
        rst_n = 1'b1;

        // Window and colour selection in ALIVE.
        vid_in.hsync = 1'b1;
        pix(11'd100, 11'd680);
        check("win_first", 32'(vid_out.rgb), 32'h0F0);
        check("hcount_out", 32'(vid_out.hcount), 32'd100);
        check("vcount_out", 32'(vid_out.vcount), 32'd680);
        check("hsync_out", 32'(vid_out.hsync), 32'h1);
        vid_in.hsync = 1'b0;
        pix(11'd183, 11'd749);
        check("win_last", 32'(vid_out.rgb), 32'h0F0);
        pix(11'd184, 11'd680);
        check("right_edge", 32'(vid_out.rgb), 32'h123);
        pix(11'd99, 11'd680);
        check("left_edge", 32'(vid_out.rgb), 32'h123);
        pix(11'd100, 11'd750);
        check("bottom_edge", 32'(vid_out.rgb), 32'h123);
        pix(11'd100, 11'd679);
        check("top_edge", 32'(vid_out.rgb), 32'h123);
        rgb_pixel = 12'hFFF;
        pix(11'd120, 11'd690);
        check("transparent", 32'(vid_out.rgb), 32'h123);
        rgb_pixel = 12'h0F0;
        vid_in.hblnk = 1'b1;
        pix(11'd120, 11'd690);
        check("hblank", 32'(vid_out.rgb), 32'h0);
        vid_in.hblnk = 1'b0;

        // Right-edge clipping and ROM address.
        xpos = 11'd2000;
        pix(11'd10, 11'd690);
        check("no_wrap", 32'(vid_out.rgb), 32'h123);
        vid_in.hcount = 11'd2010;
        vid_in.vcount = 11'd700;
        step();
        check("addr_clip", 32'(pixel_addr), 32'd2570);
        xpos = 11'd100;

        // Mid-line hit waits for the next frame tick.
        vid_in.hcount = 11'd50;
        hit = 1'b1;
        step();
        hit = 1'b0;
        step();
        step();
        check("hit_wait", 32'(frame_idx), 32'h0);
        tick();
        check("explode_f1", 32'(frame_idx), 32'h1);
        hit = 1'b1;
        respawn = 1'b1;
        step();
        hit = 1'b0;
        respawn = 1'b0;
        ticks(7);
        check("f1_hold", 32'(frame_idx), 32'h1);
        tick();
        check("explode_f2", 32'(frame_idx), 32'h2);
        ticks(8);
        check("explode_f3", 32'(frame_idx), 32'h3);
        ticks(7);
        check("f3_no_done", 32'(done_cnt), 32'h0);
        tick();
        check("done_pulse", 32'(last_done), 32'h1);
        check("done_low", 32'(anim_done), 32'h0);
        check("dead_frame", 32'(frame_idx), 32'h0);
        pix(11'd100, 11'd680);
        check("dead_absent", 32'(vid_out.rgb), 32'h123);
        ticks(2);
        check("done_once", 32'(done_cnt), 32'h1);
        pix(11'd100, 11'd680);
        check("dead_stays", 32'(vid_out.rgb), 32'h123);

        // Respawn in DEAD takes effect on the next tick.
        respawn = 1'b1;
        step();
        respawn = 1'b0;
        pix(11'd100, 11'd680);
        check("resp_wait", 32'(vid_out.rgb), 32'h123);
        tick();
        pix(11'd100, 11'd680);
        check("respawned", 32'(vid_out.rgb), 32'h0F0);

        // Hit arriving on the tick cycle acts on that tick.
        hit = 1'b1;
        vid_in.vblnk = 1'b1;
        step();
        hit = 1'b0;
        vid_in.vblnk = 1'b0;
        step();
        check("hit_on_tick", 32'(frame_idx), 32'h1);
        ticks(8);
        check("rst_pre_f2", 32'(frame_idx), 32'h2);
        pix(11'd100, 11'd680);
        check("explode_vis", 32'(vid_out.rgb), 32'h0F0);

        // Asynchronous reset mid-animation.
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rgb", 32'(vid_out.rgb), 32'h0);
        check("async_hc", 32'(vid_out.hcount), 32'h0);
        check("async_frame", 32'(frame_idx), 32'h0);
        check("async_addr", 32'(pixel_addr), 32'h0);
        step();
        rst_n = 1'b1;
        step();
        check("post_rst_c1", 32'(vid_out.rgb), 32'h0);
        step();
        check("post_rst_c2", 32'(vid_out.rgb), 32'h0F0);
        tick();
        check("post_rst_alive", 32'(frame_idx), 32'h0);
        pix(11'd100, 11'd680);
        check("post_rst_vis", 32'(vid_out.rgb), 32'h0F0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Global watchdog.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

endmodule
